// File: rtl/laa_stream_loader_if.sv
// -----------------------------------------------------------------------------
// laa_stream_loader_if
// Purpose : bundles the input stream, output stream, LAA bus and status
//           signals of the LAA stream loader.
// Modports:
//   master : loader side (accepts the input stream, drives the output stream,
//            drives the LAA bus and the busy/err status)
//   slave  : environment side (stream source/sink and the LAA itself)
// Signals :
//   in_data/in_valid/in_ready     input word stream (valid/ready)
//   out_data/out_valid/out_ready  result word stream (valid/ready)
//   laa_opcode/laa_addr/laa_wdata LAA bus command, address, write data
//   laa_rdata                     LAA read data, valid the cycle after a READ
//   busy/err                      loader status
// -----------------------------------------------------------------------------
interface laa_stream_loader_if #(
    parameter int DATA_W = 32
);
    logic [DATA_W-1:0] in_data;
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] out_data;
    logic              out_valid;
    logic              out_ready;
    logic [1:0]        laa_opcode;
    logic [4:0]        laa_addr;
    logic [DATA_W-1:0] laa_wdata;
    logic [DATA_W-1:0] laa_rdata;
    logic              busy;
    logic              err;

    modport master (
        input  in_data, in_valid, out_ready, laa_rdata,
        output in_ready, out_data, out_valid, laa_opcode, laa_addr, laa_wdata, busy, err
    );

    modport slave (
        output in_data, in_valid, out_ready, laa_rdata,
        input  in_ready, out_data, out_valid, laa_opcode, laa_addr, laa_wdata, busy, err
    );
endinterface

// File: rtl/laa_stream_loader.sv
// -----------------------------------------------------------------------------
// laa_stream_loader
// Purpose : upstream sequencer for the linear-algebra accelerator. Loads an
//           18-word frame (A00..A22, B00..B22) into the LAA with WRITEs,
//           issues MULTIPLY, polls the status word (address 31) and streams
//           the 9 result words (addresses 0..8) out on a valid/ready port.
// Ports   :
//   clk    in  system clock, all logic on posedge
//   reset  in  synchronous active-low reset
//   bus    master modport of laa_stream_loader_if (input stream, output
//          stream, LAA bus, busy, err)
// All outputs come straight from registers.
// -----------------------------------------------------------------------------
module laa_stream_loader #(
    parameter int DATA_W       = 32,
    parameter int MULT_CYCLES  = 2,
    parameter int POLL_TIMEOUT = 64
) (
    input logic                 clk,
    input logic                 reset,
    laa_stream_loader_if.master bus
);
    localparam logic [1:0] OP_NONE  = 2'd0;
    localparam logic [1:0] OP_WRITE = 2'd1;
    localparam logic [1:0] OP_READ  = 2'd2;
    localparam logic [1:0] OP_MULT  = 2'd3;
    localparam logic [4:0] ADDR_STATUS = 5'd31;

    localparam int MCW = (MULT_CYCLES > 1) ? $clog2(MULT_CYCLES + 1) : 1;
    localparam int PCW = $clog2(POLL_TIMEOUT);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_MULT,
        S_POLL,
        S_RD,
        S_RW,
        S_EMIT
    } state_t;

    state_t            r_state,     w_state;
    logic              r_in_ready,  w_in_ready;
    logic              r_out_valid, w_out_valid;
    logic [DATA_W-1:0] r_out_data,  w_out_data;
    logic [1:0]        r_opcode,    w_opcode;
    logic [4:0]        r_addr,      w_addr;
    logic [DATA_W-1:0] r_wdata,     w_wdata;
    logic              r_busy,      w_busy;
    logic              r_err,       w_err;
    logic [4:0]        r_wcnt,      w_wcnt;
    logic [3:0]        r_rcnt,      w_rcnt;
    logic [MCW-1:0]    r_mcnt,      w_mcnt;
    logic [PCW-1:0]    r_pcnt,      w_pcnt;
    logic              w_accept;

    assign w_accept = bus.in_valid & r_in_ready;

    always_comb begin
        w_state     = r_state;
        w_in_ready  = r_in_ready;
        w_out_valid = r_out_valid;
        w_out_data  = r_out_data;
        w_opcode    = OP_NONE;   // no command unless a state asks for one
        w_addr      = r_addr;    // address/data hold while the bus is idle
        w_wdata     = r_wdata;
        w_err       = r_err;
        w_wcnt      = r_wcnt;
        w_rcnt      = r_rcnt;
        w_mcnt      = r_mcnt;
        w_pcnt      = r_pcnt;

        unique case (r_state)
            S_IDLE: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    w_opcode = OP_WRITE;
                    w_addr   = 5'd0;
                    w_wdata  = bus.in_data;
                    w_err    = 1'b0;
                    w_wcnt   = 5'd1;
                    w_state  = S_LOAD;
                end
            end
            S_LOAD: begin
                w_in_ready = 1'b1;
                if (w_accept) begin
                    w_opcode = OP_WRITE;
                    w_addr   = r_wcnt;
                    w_wdata  = bus.in_data;
                    if (r_wcnt == 5'd17) begin
                        // The WRITE to address 17 appears in the first MULT cycle.
                        w_in_ready = 1'b0;
                        w_mcnt     = '0;
                        w_state    = S_MULT;
                    end else begin
                        w_wcnt = r_wcnt + 5'd1;
                    end
                end
            end
            S_MULT: begin
                if (r_mcnt != MCW'(MULT_CYCLES)) begin
                    w_opcode = OP_MULT;
                    w_mcnt   = r_mcnt + MCW'(1);
                end else begin
                    w_opcode = OP_READ;
                    w_addr   = ADDR_STATUS;
                    w_pcnt   = '0;
                    w_state  = S_POLL;
                end
            end
            S_POLL: begin
                // A status READ is on the bus in every POLL cycle; its data is
                // visible one cycle later, so the first POLL cycle has nothing
                // to look at yet.
                if ((r_pcnt != '0) && bus.laa_rdata[0]) begin
                    // Present the READ of result word 0 directly: RD is the
                    // cycle in which the result READ is on the bus.
                    w_opcode = OP_READ;
                    w_addr   = 5'd0;
                    w_rcnt   = 4'd0;
                    w_state  = S_RD;
                end else if (r_pcnt == PCW'(POLL_TIMEOUT - 1)) begin
                    w_err      = 1'b1;
                    w_in_ready = 1'b1;
                    w_state    = S_IDLE;
                end else begin
                    w_opcode = OP_READ;
                    w_addr   = ADDR_STATUS;
                    w_pcnt   = r_pcnt + PCW'(1);
                end
            end
            S_RD: begin
                w_state = S_RW;
            end
            S_RW: begin
                // laa_rdata now carries the word requested during RD.
                w_out_data  = bus.laa_rdata;
                w_out_valid = 1'b1;
                w_state     = S_EMIT;
            end
            S_EMIT: begin
                if (r_out_valid && bus.out_ready) begin
                    w_out_valid = 1'b0;
                    if (r_rcnt == 4'd8) begin
                        w_in_ready = 1'b1;
                        w_state    = S_IDLE;
                    end else begin
                        w_rcnt   = r_rcnt + 4'd1;
                        w_opcode = OP_READ;
                        w_addr   = {1'b0, r_rcnt + 4'd1};
                        w_state  = S_RD;
                    end
                end
            end
            default: begin
                w_state = S_IDLE;
            end
        endcase

        w_busy = (w_state != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_out_data  <= '0;
            r_opcode    <= OP_NONE;
            r_addr      <= 5'd0;
            r_wdata     <= '0;
            r_busy      <= 1'b0;
            r_err       <= 1'b0;
            r_wcnt      <= 5'd0;
            r_rcnt      <= 4'd0;
            r_mcnt      <= '0;
            r_pcnt      <= '0;
        end else begin
            r_state     <= w_state;
            r_in_ready  <= w_in_ready;
            r_out_valid <= w_out_valid;
            r_out_data  <= w_out_data;
            r_opcode    <= w_opcode;
            r_addr      <= w_addr;
            r_wdata     <= w_wdata;
            r_busy      <= w_busy;
            r_err       <= w_err;
            r_wcnt      <= w_wcnt;
            r_rcnt      <= w_rcnt;
            r_mcnt      <= w_mcnt;
            r_pcnt      <= w_pcnt;
        end
    end

    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_out_valid;
    assign bus.out_data   = r_out_data;
    assign bus.laa_opcode = r_opcode;
    assign bus.laa_addr   = r_addr;
    assign bus.laa_wdata  = r_wdata;
    assign bus.busy       = r_busy;
    assign bus.err        = r_err;
endmodule
